b_resp_router: RTL

//  Write-response (B channel) return path of the 2-master interconnect; mirrors the AW mux.
//  For every AW handshake it records the issuing master in a per-slave order FIFO.

---
 rtl/axi_ic_pkg.sv | 18 +
 rtl/b_order_fifo.sv | 49 ++++
 rtl/b_resp_router.sv | 129 ++++++++++++
 3 files changed

// File: rtl/axi_ic_pkg.sv
// Shared interconnect types: response encoding, slave index, width helper.
package axi_ic_pkg;

    localparam int SLV_W = 2;
    typedef logic [SLV_W-1:0] slv_idx_t;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // Index width for n items, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/b_order_fifo.sv
// Per-slave order FIFO: remembers which master issued each outstanding AW.
// Pointers carry an extra wrap bit so full/empty need no separate counter.
module b_order_fifo
    import axi_ic_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]             wr_ptr, rd_ptr;
    logic [DEPTH-1:0][W-1:0] mem;
    logic                    do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // full is taken from the pre-pop state, so push on a full FIFO is dropped
    // even when a pop happens in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; a reset discards every outstanding entry.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage; contents only matter behind the pointers, so no reset.
    always_ff @(posedge ACLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/b_resp_router.sv
// B-channel return path: steers each slave's write response to the master
// at the head of that slave's order FIFO, with per-master round-robin and a
// grant lock that keeps BVALID/BRESP stable until the master accepts.
module b_resp_router
    import axi_ic_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int DEPTH       = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          aw_push,
    input  logic [idx_w(NUM_MASTERS)-1:0] aw_master,
    input  slv_idx_t                      aw_slave,
    output logic [NUM_SLAVES-1:0]         aw_slot_ok,
    input  logic [NUM_SLAVES-1:0]         S_BVALID,
    input  logic [2*NUM_SLAVES-1:0]       S_BRESP,
    output logic [NUM_SLAVES-1:0]         S_BREADY,
    output logic [NUM_MASTERS-1:0]        M_BVALID,
    output logic [2*NUM_MASTERS-1:0]      M_BRESP,
    input  logic [NUM_MASTERS-1:0]        M_BREADY,
    output logic                          err_orphan
);

    localparam int MW = idx_w(NUM_MASTERS);
    localparam int SW = idx_w(NUM_SLAVES);

    logic [NUM_SLAVES-1:0]                  f_push, f_pop, f_empty, f_full, orphan, s_rdy;
    logic [NUM_SLAVES-1:0][MW-1:0]          f_head;
    resp_t [NUM_SLAVES-1:0]                 s_resp;
    resp_t [NUM_MASTERS-1:0]                m_resp;
    logic [NUM_MASTERS-1:0][NUM_SLAVES-1:0] cand;
    logic [NUM_MASTERS-1:0]                 sel_vld, m_bv, gnt_lock;
    logic [NUM_MASTERS-1:0][SW-1:0]         sel, gnt_idx, rr_ptr;
    logic [SW:0]                            idx;

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_fifo
        assign f_push[s] = aw_push && (aw_slave == slv_idx_t'(s));
        b_order_fifo #(.W(MW), .DEPTH(DEPTH)) u_fifo (
            .ACLK    (ACLK),
            .ARESETN (ARESETN),
            .push    (f_push[s]),
            .din     (aw_master),
            .pop     (f_pop[s]),
            .head    (f_head[s]),
            .empty   (f_empty[s]),
            .full    (f_full[s])
        );
    end

    assign aw_slot_ok = ~f_full;
    assign s_resp     = S_BRESP;
    // a response with nothing outstanding is drained and dropped
    assign orphan     = S_BVALID & f_empty;

    // Candidate build and slave selection per master. rr_ptr holds the
    // highest-priority slave, i.e. the one after the last served.
    always_comb begin
        cand    = '0;
        sel_vld = '0;
        sel     = '0;
        idx     = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            for (int s = 0; s < NUM_SLAVES; s++)
                cand[m][s] = S_BVALID[s] && !f_empty[s] && (f_head[s] == MW'(m));
            if (gnt_lock[m]) begin
                sel_vld[m] = 1'b1;
                sel[m]     = gnt_idx[m];
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    idx = {1'b0, rr_ptr[m]} + (SW+1)'(i);
                    if (idx >= (SW+1)'(NUM_SLAVES)) idx = idx - (SW+1)'(NUM_SLAVES);
                    if (!sel_vld[m] && cand[m][idx[SW-1:0]]) begin
                        sel_vld[m] = 1'b1;
                        sel[m]     = idx[SW-1:0];
                    end
                end
            end
        end
    end

    // Zero-latency data path: selected slave drives the master, master's
    // ready goes back to that slave only.
    always_comb begin
        m_bv   = '0;
        m_resp = {NUM_MASTERS{RESP_OKAY}};
        s_rdy  = orphan;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (sel_vld[m]) begin
                m_bv[m]   = S_BVALID[sel[m]];
                m_resp[m] = s_resp[sel[m]];
                if (M_BREADY[m]) s_rdy[sel[m]] = 1'b1;
            end
        end
    end

    // outputs are forced idle while reset is held, independent of the clock
    assign M_BVALID = ARESETN ? m_bv   : '0;
    assign M_BRESP  = ARESETN ? m_resp : '0;
    assign S_BREADY = ARESETN ? s_rdy  : '0;
    assign f_pop    = S_BVALID & s_rdy & ~f_empty;

    // Grant lock and round-robin advance on master-side handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gnt_lock <= '0;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (m_bv[m] && M_BREADY[m]) begin
                    gnt_lock[m] <= 1'b0;
                    rr_ptr[m]   <= (sel[m] == SW'(NUM_SLAVES-1)) ? '0 : sel[m] + SW'(1);
                end else if (m_bv[m]) begin
                    gnt_lock[m] <= 1'b1;
                    gnt_idx[m]  <= sel[m];
                end
            end
        end
    end

    // Sticky orphan flag, cleared only by reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) err_orphan <= 1'b0;
        else          err_orphan <= err_orphan | (|orphan);
    end

endmodule
